// File: rtl/pl_pkg.sv
// Shared types and helpers for the forwarding/hazard unit.
//   REG_X0          : architectural zero register, never forwarded or stalled on
//   shadow_entry_t  : one in-flight destination record of the shadow pipeline
//   fwd_sel_w()     : width of a forward select able to encode 0..fwd_stages
package pl_pkg;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wren;
    logic       is_load;
  } shadow_entry_t;

  function automatic int fwd_sel_w(input int fwd_stages);
    return $clog2(fwd_stages + 1);
  endfunction

endpackage

// File: rtl/fwd_operand_mux.sv
// Per-operand forward mux.
//   sel_i        : 0 = register-file operand, k = i_stage_data[k-1]
//   rs_data_i    : register-file operand in EX
//   stage_data_i : results of MEM (idx 0) .. last forwarding stage
//   operand_o    : selected ALU operand; an out-of-range select gives 0
module fwd_operand_mux #(
  parameter int XLEN       = 32,
  parameter int FWD_STAGES = 2,
  parameter int SELW       = pl_pkg::fwd_sel_w(FWD_STAGES)
) (
  input  logic [SELW-1:0]                  sel_i,
  input  logic [XLEN-1:0]                  rs_data_i,
  input  logic [FWD_STAGES-1:0][XLEN-1:0]  stage_data_i,
  output logic [XLEN-1:0]                  operand_o
);

  always_comb begin
    operand_o = '0;
    if (sel_i == '0) begin
      operand_o = rs_data_i;
    end else begin
      for (int k = 0; k < FWD_STAGES; k++)
        if (sel_i == SELW'(k + 1)) operand_o = stage_data_i[k];
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding / load-use hazard unit for the pipelined RV32I core.
// Tracks in-flight destinations (EX..last forwarding stage) in a shadow
// pipeline, registers per-operand forward selects for the instruction
// entering EX, raises a stall on load-use hazards and counts stall cycles.
//   i_clk, i_rst   : clock, async active-high reset
//   i_hold         : global freeze, no state changes
//   i_flush        : kill the instruction entering EX
//   i_id_*         : decoded info of the instruction in ID
//   i_rs_data_ex   : register-file operands of the instruction in EX
//   i_stage_data   : MEM (idx 0) .. last stage results
//   o_stall        : hold PC + IF/ID, bubble into EX (combinational)
//   o_fwd_sel      : registered forward selects of the instruction in EX
//   o_operand_fwd  : forwarded ALU operands
//   o_stall_cnt    : saturating count of stall cycles
// FWD_STAGES must be at least LOAD_LAT+1 so a stalled load always lands in
// a forwardable stage.
module fwd_hazard_unit
  import pl_pkg::*;
#(
  parameter  int XLEN       = 32,
  parameter  int NUM_SRC    = 2,
  parameter  int FWD_STAGES = 2,
  parameter  int LOAD_LAT   = 1,
  localparam int SELW       = fwd_sel_w(FWD_STAGES)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_hold,
  input  logic                             i_flush,
  input  logic                             i_id_valid,
  input  logic [NUM_SRC-1:0][4:0]          i_id_rs_addr,
  input  logic [4:0]                       i_id_rd_addr,
  input  logic                             i_id_rd_wren,
  input  logic                             i_id_is_load,
  input  logic [NUM_SRC-1:0][XLEN-1:0]     i_rs_data_ex,
  input  logic [FWD_STAGES-1:0][XLEN-1:0]  i_stage_data,
  output logic                             o_stall,
  output logic [NUM_SRC-1:0][SELW-1:0]     o_fwd_sel,
  output logic [NUM_SRC-1:0][XLEN-1:0]     o_operand_fwd,
  output logic [31:0]                      o_stall_cnt
);

  shadow_entry_t [FWD_STAGES:0]     shadow_q, shadow_d;
  logic [NUM_SRC-1:0][SELW-1:0]     sel_q, sel_d;
  logic [31:0]                      cnt_q, cnt_d;
  logic [NUM_SRC-1:0][FWD_STAGES:0] match;
  logic                             load_hit;

  // match[s][p]: shadow entry p produces the register source s reads
  always_comb begin
    match = '0;
    for (int s = 0; s < NUM_SRC; s++)
      for (int p = 0; p <= FWD_STAGES; p++)
        match[s][p] = shadow_q[p].valid & shadow_q[p].wren &
                      (shadow_q[p].rd != REG_X0) &
                      (shadow_q[p].rd == i_id_rs_addr[s]);
  end

  // A load younger than LOAD_LAT stages cannot supply data in time.
  always_comb begin
    load_hit = 1'b0;
    for (int s = 0; s < NUM_SRC; s++)
      for (int p = 0; p < LOAD_LAT; p++)
        if (match[s][p] && shadow_q[p].is_load) load_hit = 1'b1;
    o_stall = i_id_valid & ~i_flush & load_hit;
  end

  // Entry p sits at source idx p once the ID instruction reaches EX.
  // Scan oldest to youngest so the nearest producer wins.
  always_comb begin
    sel_d = '0;
    for (int s = 0; s < NUM_SRC; s++)
      for (int p = FWD_STAGES - 1; p >= 0; p--)
        if (match[s][p]) sel_d[s] = SELW'(p + 1);
    if (o_stall || i_flush) sel_d = '0;
  end

  always_comb begin
    shadow_d[0].valid   = i_id_valid & ~o_stall & ~i_flush;
    shadow_d[0].rd      = i_id_rd_addr;
    shadow_d[0].wren    = i_id_rd_wren;
    shadow_d[0].is_load = i_id_is_load;
    for (int p = 1; p <= FWD_STAGES; p++) shadow_d[p] = shadow_q[p-1];
  end

  assign cnt_d = (o_stall && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shadow_q <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
    end else if (!i_hold) begin
      shadow_q <= shadow_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_operand_mux #(
      .XLEN      (XLEN),
      .FWD_STAGES(FWD_STAGES),
      .SELW      (SELW)
    ) u_mux (
      .sel_i       (sel_q[s]),
      .rs_data_i   (i_rs_data_ex[s]),
      .stage_data_i(i_stage_data),
      .operand_o   (o_operand_fwd[s])
    );
  end

  assign o_fwd_sel   = sel_q;
  assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two configurations share one stimulus stream
//   A: NUM_SRC=2, FWD_STAGES=2, LOAD_LAT=1
//   B: NUM_SRC=3, FWD_STAGES=3, LOAD_LAT=2
// The reference keeps a queue of issued instructions (youngest first) and
// derives stalls, selects, operands and counters from producer ages.
module tb_fwd_hazard_unit;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                  hold, flush, id_valid, rd_wren, is_load;
  logic [2:0][4:0]       rs;
  logic [4:0]            rd;
  logic [2:0][XLEN-1:0]  rs_data, stage_data;

  logic                  stall_a, stall_b;
  logic [1:0][1:0]       sel_a;
  logic [2:0][1:0]       sel_b;
  logic [1:0][XLEN-1:0]  opnd_a;
  logic [2:0][XLEN-1:0]  opnd_b;
  logic [31:0]           cnt_a, cnt_b;

  fwd_hazard_unit #(.XLEN(XLEN), .NUM_SRC(2), .FWD_STAGES(2), .LOAD_LAT(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_hold(hold), .i_flush(flush),
    .i_id_valid(id_valid), .i_id_rs_addr(rs[1:0]), .i_id_rd_addr(rd),
    .i_id_rd_wren(rd_wren), .i_id_is_load(is_load),
    .i_rs_data_ex(rs_data[1:0]), .i_stage_data(stage_data[1:0]),
    .o_stall(stall_a), .o_fwd_sel(sel_a), .o_operand_fwd(opnd_a), .o_stall_cnt(cnt_a)
  );

  fwd_hazard_unit #(.XLEN(XLEN), .NUM_SRC(3), .FWD_STAGES(3), .LOAD_LAT(2)) u_b (
    .i_clk(clk), .i_rst(rst), .i_hold(hold), .i_flush(flush),
    .i_id_valid(id_valid), .i_id_rs_addr(rs), .i_id_rd_addr(rd),
    .i_id_rd_wren(rd_wren), .i_id_is_load(is_load),
    .i_rs_data_ex(rs_data), .i_stage_data(stage_data),
    .o_stall(stall_b), .o_fwd_sel(sel_b), .o_operand_fwd(opnd_b), .o_stall_cnt(cnt_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit [4:0] rd; bit w; bit ld; bit va; bit vb; } rec_t;
  rec_t        hist[$];          // hist[a]: instruction that entered EX a+1 cycles ago
  logic [1:0]  sel_m [2][3];
  logic [31:0] cnt_m [2];

  function automatic bit live(int inst, int a);
    return (inst == 0) ? hist[a].va : hist[a].vb;
  endfunction

  // age of the youngest writer of r among the first lim ages, -1 if none
  function automatic int nearest(int inst, bit [4:0] r, int lim);
    if (r == 5'd0) return -1;
    for (int a = 0; a < lim && a < hist.size(); a++)
      if (live(inst, a) && hist[a].w && hist[a].rd == r) return a;
    return -1;
  endfunction

  function automatic bit load_hit(int inst, bit [4:0] r, int lat);
    if (r == 5'd0) return 1'b0;
    for (int a = 0; a < lat && a < hist.size(); a++)
      if (live(inst, a) && hist[a].w && hist[a].ld && hist[a].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < 2; i++) begin
      cnt_m[i] = '0;
      for (int s = 0; s < 3; s++) sel_m[i][s] = '0;
    end
  endtask

  // check outputs at negedge, advance model, return at posedge+1
  task automatic step();
    bit          st [2];
    int          ns, lat, a, k;
    logic [1:0]  sa;
    logic [31:0] oa, oe;
    rec_t        r;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      ns  = (i == 0) ? 2 : 3;
      lat = (i == 0) ? 1 : 2;
      st[i] = 1'b0;
      if (id_valid && !flush)
        for (int s = 0; s < ns; s++) if (load_hit(i, rs[s], lat)) st[i] = 1'b1;
      chk(i == 0 ? "stall_a" : "stall_b", (i == 0) ? stall_a : stall_b, st[i]);
      for (int s = 0; s < ns; s++) begin
        if (i == 0) begin sa = sel_a[s]; oa = opnd_a[s]; end
        else        begin sa = sel_b[s]; oa = opnd_b[s]; end
        k  = int'(sel_m[i][s]) - 1;
        oe = (sel_m[i][s] == 2'd0) ? rs_data[s] : stage_data[k];
        chk(i == 0 ? "sel_a" : "sel_b", sa, sel_m[i][s]);
        chk(i == 0 ? "opnd_a" : "opnd_b", oa, oe);
      end
      chk(i == 0 ? "cnt_a" : "cnt_b", (i == 0) ? cnt_a : cnt_b, cnt_m[i]);
    end
    if (!hold) begin
      for (int i = 0; i < 2; i++) begin
        ns = (i == 0) ? 2 : 3;
        if (st[i] && cnt_m[i] != 32'hFFFF_FFFF) cnt_m[i] = cnt_m[i] + 32'd1;
        for (int s = 0; s < ns; s++) begin
          a = nearest(i, rs[s], ns);   // FWD_STAGES equals NUM_SRC in both configs
          sel_m[i][s] = (st[i] || flush || a < 0) ? 2'd0 : 2'(a + 1);
        end
      end
      r.rd = rd; r.w = rd_wren; r.ld = is_load;
      r.va = id_valid && !st[0] && !flush;
      r.vb = id_valid && !st[1] && !flush;
      hist.push_front(r);
      if (hist.size() > 4) void'(hist.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, bit [4:0] d, bit w, bit ld,
                       bit [4:0] r0, bit [4:0] r1, bit [4:0] r2, bit fl, bit hd);
    id_valid = v; rd = d; rd_wren = w; is_load = ld;
    rs[0] = r0; rs[1] = r1; rs[2] = r2; flush = fl; hold = hd;
    for (int k = 0; k < 3; k++) begin
      rs_data[k]    = $urandom;
      stage_data[k] = $urandom;
    end
  endtask

  task automatic issue(bit v, bit [4:0] d, bit w, bit ld,
                       bit [4:0] r0, bit [4:0] r1, bit [4:0] r2, bit fl, bit hd);
    drive(v, d, w, ld, r0, r1, r2, fl, hd);
    step();
  endtask

  task automatic drain();
    repeat (4) issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_stall"}, {stall_a, stall_b}, 2'b00);
    chk({tag, "_sel"}, {sel_a, sel_b}, '0);
    chk({tag, "_cnt"}, {cnt_a, cnt_b}, '0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // ALU chain: add x5, then sub reading x5 -> MEM forward
    drain();
    issue(1, 5, 1, 0, 1, 2, 0, 0, 0);
    issue(1, 8, 1, 0, 5, 3, 0, 0, 0);
    chk("alu_sel_a", sel_a[0], 2'd1);
    chk("alu_sel_b", sel_b[0], 2'd1);
    stage_data[0] = 32'h1234;
    #1;
    chk("alu_opnd_a", opnd_a[0], 32'h1234);
    chk("alu_opnd_b", opnd_b[0], 32'h1234);

    // load-use on rs2: A forwards from WB, B one cycle later from stage 3
    drain();
    issue(1, 6, 1, 1, 1, 2, 0, 0, 0);
    issue(1, 9, 1, 0, 3, 6, 0, 0, 0);
    issue(1, 9, 1, 0, 3, 6, 0, 0, 0);
    chk("lu_sel_a", sel_a[1], 2'd2);
    issue(1, 9, 1, 0, 3, 6, 6, 0, 0);
    chk("lu_sel_b", sel_b[1], 2'd3);
    drain();

    // x0 writer is never a producer, not even a load
    issue(1, 0, 1, 1, 1, 2, 0, 0, 0);
    issue(1, 9, 1, 0, 0, 0, 0, 0, 0);
    chk("x0_sel_a", sel_a, '0);

    // same rd in EX and MEM entries: nearest wins
    drain();
    issue(1, 7, 1, 0, 1, 2, 0, 0, 0);
    issue(1, 7, 1, 0, 3, 4, 0, 0, 0);
    issue(1, 9, 1, 0, 7, 1, 7, 0, 0);
    chk("prio_sel_a", sel_a[0], 2'd1);
    chk("prio_sel_b", sel_b[2], 2'd1);

    // flush during load-use: no stall, bubble into EX
    drain();
    issue(1, 6, 1, 1, 1, 2, 0, 0, 0);
    drive(1, 9, 1, 0, 6, 6, 6, 1, 0);
    #1;
    chk("flush_stall", {stall_a, stall_b}, 2'b00);
    step();
    chk("flush_sel", {sel_a, sel_b}, '0);

    // hold across a load-use: stall visible, state frozen
    drain();
    issue(1, 6, 1, 1, 1, 2, 0, 0, 0);
    repeat (3) issue(1, 9, 1, 0, 6, 1, 0, 0, 1);
    issue(1, 9, 1, 0, 6, 1, 0, 0, 0);
    issue(1, 9, 1, 0, 6, 1, 0, 0, 0);

    // async reset in the middle of a load-use stall
    drain();
    issue(1, 6, 1, 1, 1, 2, 0, 0, 0);
    drive(1, 9, 1, 0, 6, 2, 0, 0, 0);
    #1;
    chk("pre_rst_stall", {stall_a, stall_b}, 2'b11);
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // random traffic over a small register set to provoke hazards
    repeat (500) begin
      issue($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 4) != 0,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
